// File: rtl/cam_pkg.sv
// cam_pkg: shared types and default sizes for the CAM search responder.
//   cam_state_e  - responder control states (IDLE, SEARCH, DONE)
//   DEPTH_DEF, ADDR_W_DEF, KEY_W_DEF - default entry count, index width, key width
package cam_pkg;

  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned KEY_W_DEF  = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_search_responder_if.sv
// cam_search_responder_if: CAM handshake between the control FSM (master)
// and the search responder (slave).
//   master -> slave : cam_write_en, cam_start, address_in, key_in, clear_all
//   slave -> master : busy, search_done, match, match_addr, free_addr, full,
//                     write_drop
interface cam_search_responder_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned KEY_W  = 128
);

  logic              cam_write_en;
  logic              cam_start;
  logic [ADDR_W-1:0] address_in;
  logic [KEY_W-1:0]  key_in;
  logic              clear_all;
  logic              busy;
  logic              search_done;
  logic              match;
  logic [ADDR_W-1:0] match_addr;
  logic [ADDR_W-1:0] free_addr;
  logic              full;
  logic              write_drop;

  modport master (
    output cam_write_en, cam_start, address_in, key_in, clear_all,
    input  busy, search_done, match, match_addr, free_addr, full, write_drop
  );

  modport slave (
    input  cam_write_en, cam_start, address_in, key_in, clear_all,
    output busy, search_done, match, match_addr, free_addr, full, write_drop
  );

endinterface

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-set-bit priority encoder.
//   vec   in  WIDTH  request vector
//   idx   out IDX_W  index of the lowest set bit (0 when none set)
//   found out 1      at least one bit of vec is set
module cam_prio_enc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (vec[i-1]) begin
        idx   = IDX_W'(i - 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_search_responder.sv
// cam_search_responder: stores DEPTH keys with valid bits and answers
// searches from the control FSM with match / match_addr.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (key storage is not reset)
//   bus    cam_search_responder_if.slave:
//            cam_write_en, cam_start, address_in, key_in, clear_all (in)
//            busy, search_done, match, match_addr, free_addr, full,
//            write_drop (out)
// Build option: define CAM_PARALLEL_EN to compare all entries in a single
// SEARCH cycle; otherwise one comparator scans entries one per cycle.
module cam_search_responder
  import cam_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned KEY_W  = KEY_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cam_search_responder_if.slave  bus
);

  cam_state_e        state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [KEY_W-1:0]  key_mem_q [DEPTH];
  logic [KEY_W-1:0]  search_key_q, search_key_d;
  logic              match_q, match_d;
  logic [ADDR_W-1:0] match_addr_q, match_addr_d;
  logic [ADDR_W-1:0] free_addr_q, free_addr_d;
  logic              full_q, full_d;
  logic              write_drop_q, write_drop_d;
  logic              wr_en;

  logic              hit;
  logic [ADDR_W-1:0] hit_idx;
  logic              scan_last;

  logic [ADDR_W-1:0] free_idx;
  logic              free_found;

`ifdef CAM_PARALLEL_EN
  logic [DEPTH-1:0]  hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_q[i] && (key_mem_q[i] == search_key_q);
    end
  end

  cam_prio_enc #(
    .WIDTH (DEPTH),
    .IDX_W (ADDR_W)
  ) u_hit_enc (
    .vec   (hit_vec),
    .idx   (hit_idx),
    .found (hit)
  );

  assign scan_last = 1'b1;
`else
  logic [ADDR_W-1:0] idx_q, idx_d;

  assign hit       = valid_q[idx_q] && (key_mem_q[idx_q] == search_key_q);
  assign hit_idx   = idx_q;
  assign scan_last = (idx_q == ADDR_W'(DEPTH - 1));
`endif

  cam_prio_enc #(
    .WIDTH (DEPTH),
    .IDX_W (ADDR_W)
  ) u_free_enc (
    .vec   (~valid_q),
    .idx   (free_idx),
    .found (free_found)
  );

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    search_key_d = search_key_q;
    match_d      = match_q;
    match_addr_d = match_addr_q;
    write_drop_d = 1'b0;
    wr_en        = 1'b0;
`ifndef CAM_PARALLEL_EN
    idx_d        = idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cam_write_en) begin
          if (bus.clear_all) write_drop_d = 1'b1;
          else               wr_en        = 1'b1;
        end
        // A same-cycle write lands in storage at this edge, so the scan
        // that starts next cycle already sees it.
        if (bus.cam_start) begin
          search_key_d = bus.key_in;
          match_d      = 1'b0;
`ifndef CAM_PARALLEL_EN
          idx_d        = '0;
`endif
          state_d      = SEARCH;
        end
      end

      SEARCH: begin
        if (bus.cam_write_en) write_drop_d = 1'b1;
        // A clear invalidates every entry, so the search ends as a miss.
        if (bus.clear_all) begin
          match_d      = 1'b0;
          match_addr_d = '0;
          state_d      = DONE;
        end else if (hit) begin
          match_d      = 1'b1;
          match_addr_d = hit_idx;
          state_d      = DONE;
        end else if (scan_last) begin
          match_d      = 1'b0;
          match_addr_d = '0;
          state_d      = DONE;
        end else begin
`ifndef CAM_PARALLEL_EN
          idx_d        = idx_q + 1'b1;
`endif
        end
      end

      DONE: begin
        if (bus.cam_write_en) write_drop_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (wr_en)         valid_d[bus.address_in] = 1'b1;
    if (bus.clear_all) valid_d = '0;
  end

  assign free_addr_d = free_found ? free_idx : '0;
  assign full_d      = &valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      search_key_q <= '0;
      match_q      <= 1'b0;
      match_addr_q <= '0;
      free_addr_q  <= '0;
      full_q       <= 1'b0;
      write_drop_q <= 1'b0;
`ifndef CAM_PARALLEL_EN
      idx_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      search_key_q <= search_key_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
      free_addr_q  <= free_addr_d;
      full_q       <= full_d;
      write_drop_q <= write_drop_d;
`ifndef CAM_PARALLEL_EN
      idx_q        <= idx_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) key_mem_q[bus.address_in] <= bus.key_in;
  end

  assign bus.busy        = (state_q == SEARCH);
  assign bus.search_done = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_addr  = match_addr_q;
  assign bus.free_addr   = free_addr_q;
  assign bus.full        = full_q;
  assign bus.write_drop  = write_drop_q;

endmodule

// File: tb/tb_cam_search_responder.sv
// tb_cam_search_responder: directed and randomized checks of the CAM search
// responder against an array-based reference of the key table.
module tb_cam_search_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned KW    = 128;
`ifdef CAM_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam int ACT_NONE  = 0;
  localparam int ACT_CLR   = 1;
  localparam int ACT_WR    = 2;
  localparam int ACT_START = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cam_search_responder_if #(.ADDR_W(AW), .KEY_W(KW)) bus ();

  cam_search_responder #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .KEY_W  (KW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [KW-1:0] m_key   [DEPTH];
  bit            m_valid [DEPTH];

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_lookup(input logic [KW-1:0] k, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && m_key[i] == k) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endfunction

  function automatic int model_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input int a, input logic [KW-1:0] k, input bit clr);
    bus.cam_write_en = 1'b1;
    bus.address_in   = AW'(a);
    bus.key_in       = k;
    bus.clear_all    = clr;
    @(posedge clk); #1;
    bus.cam_write_en = 1'b0;
    bus.clear_all    = 1'b0;
    check("write_drop", bus.write_drop, clr);
    if (clr) model_clear();
    else begin
      m_valid[a] = 1'b1;
      m_key[a]   = k;
    end
  endtask

  task automatic check_status();
    @(posedge clk); #1;
    check("free_addr", bus.free_addr, model_free());
    check("full", bus.full, model_full());
  endtask

  task automatic do_search(input logic [KW-1:0] k, input int act_n, input int act_kind,
                           input int act_addr, input logic [KW-1:0] act_key,
                           input bit sw, input int sw_addr);
    bit exp_hit;
    int exp_idx;
    int exp_lat;
    int got_lat;
    bus.cam_start = 1'b1;
    bus.key_in    = k;
    if (sw) begin
      bus.cam_write_en = 1'b1;
      bus.address_in   = AW'(sw_addr);
      m_valid[sw_addr] = 1'b1;
      m_key[sw_addr]   = k;
    end
    model_lookup(k, exp_hit, exp_idx);
    if (PAR)          exp_lat = 2;
    else if (exp_hit) exp_lat = 2 + exp_idx;
    else              exp_lat = 1 + DEPTH;
    if (act_kind == ACT_CLR && act_n + 1 <= exp_lat) begin
      exp_hit = 1'b0;
      exp_idx = 0;
      exp_lat = act_n + 1;
    end
    got_lat = 0;
    for (int n = 1; n <= 40 && got_lat == 0; n++) begin
      @(posedge clk); #1;
      bus.cam_start    = 1'b0;
      bus.cam_write_en = 1'b0;
      bus.clear_all    = 1'b0;
      if (n == 1) check("busy_in_search", bus.busy, 1'b1);
      if (act_kind == ACT_WR && n == act_n + 1) check("write_drop_busy", bus.write_drop, 1'b1);
      if (bus.search_done) got_lat = n;
      else if (n == act_n) begin
        case (act_kind)
          ACT_CLR: begin
            bus.clear_all = 1'b1;
            model_clear();
          end
          ACT_WR: begin
            bus.cam_write_en = 1'b1;
            bus.address_in   = AW'(act_addr);
            bus.key_in       = act_key;
          end
          ACT_START: begin
            bus.cam_start = 1'b1;
            bus.key_in    = k;
          end
          default: ;
        endcase
      end
    end
    check("latency", got_lat, exp_lat);
    check("match", bus.match, exp_hit);
    check("match_addr", bus.match_addr, exp_idx);
    @(posedge clk); #1;
    check("done_one_cycle", bus.search_done, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] k0, k1, kdup;
    int cnt, vi;
    bit any;

    rst_n            = 1'b0;
    bus.cam_write_en = 1'b0;
    bus.cam_start    = 1'b0;
    bus.address_in   = '0;
    bus.key_in       = '0;
    bus.clear_all    = 1'b0;
    model_clear();
    for (int i = 0; i < DEPTH; i++) m_key[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_search_done", bus.search_done, 1'b0);
    check("rst_match", bus.match, 1'b0);
    check("rst_match_addr", bus.match_addr, 0);
    check("rst_free_addr", bus.free_addr, 0);
    check("rst_full", bus.full, 1'b0);
    check("rst_write_drop", bus.write_drop, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Keys 0xA5.. at 0..3, search the one at address 2.
    for (int i = 0; i < 4; i++) do_write(i, KW'(128'hA5 + i), 1'b0);
    check_status();
    do_search(KW'(128'hA7), 0, ACT_NONE, 0, '0, 1'b0, 0);

    // Key never written: full-length miss.
    do_search(rand_key(), 0, ACT_NONE, 0, '0, 1'b0, 0);

    // Duplicate key: lowest index must win.
    kdup = rand_key();
    do_write(9, kdup, 1'b0);
    do_write(6, kdup, 1'b0);
    check_status();
    do_search(kdup, 0, ACT_NONE, 0, '0, 1'b0, 0);

    // Random writes and searches.
    for (int r = 0; r < 8; r++) begin
      do_write(int'($urandom_range(0, DEPTH - 1)), rand_key(), 1'b0);
      check_status();
      k0 = rand_key();
      if ($urandom_range(0, 1) == 1) begin
        vi = int'($urandom_range(0, DEPTH - 1));
        any = 1'b0;
        for (int j = 0; j < DEPTH && !any; j++) begin
          if (m_valid[(vi + j) % DEPTH]) begin
            k0 = m_key[(vi + j) % DEPTH];
            any = 1'b1;
          end
        end
      end
      do_search(k0, 0, ACT_NONE, 0, '0, 1'b0, 0);
    end

    // Fill the table, then clear it mid-search.
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) do_write(i, rand_key(), 1'b0);
    check_status();
    check("full_after_fill", bus.full, 1'b1);
    check("free_after_fill", bus.free_addr, 0);
    do_search(m_key[DEPTH-1], PAR ? 1 : 3, ACT_CLR, 0, '0, 1'b0, 0);
    check_status();

    // Write while searching is dropped and leaves the entry unchanged.
    k0 = rand_key();
    k1 = rand_key();
    do_write(7, k0, 1'b0);
    check_status();
    do_search(rand_key(), 1, ACT_WR, 7, k1, 1'b0, 0);
    do_search(k1, 0, ACT_NONE, 0, '0, 1'b0, 0);
    do_search(k0, 0, ACT_NONE, 0, '0, 1'b0, 0);

    // clear_all with a write in IDLE: clear wins, write dropped.
    do_write(3, k1, 1'b1);
    check_status();
    do_search(k1, 0, ACT_NONE, 0, '0, 1'b0, 0);

    // Same-cycle write and start on address 5; second start while busy.
    k0 = rand_key();
    do_search(k0, 1, ACT_START, 0, '0, 1'b1, 5);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.search_done) cnt++;
    end
    check("extra_search_done", cnt, 0);
    check("match_held", bus.match, 1'b1);

    // Reset in the middle of a search.
    for (int i = 0; i < 3; i++) do_write(i, rand_key(), 1'b0);
    check_status();
    k0 = m_key[0];
    bus.cam_start = 1'b1;
    bus.key_in    = rand_key();
    @(posedge clk); #1;
    bus.cam_start = 1'b0;
    check("busy_before_reset", bus.busy, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_search_done", bus.search_done, 1'b0);
    check("mid_rst_match", bus.match, 1'b0);
    check("mid_rst_match_addr", bus.match_addr, 0);
    check("mid_rst_free_addr", bus.free_addr, 0);
    check("mid_rst_full", bus.full, 1'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status();
    do_search(k0, 0, ACT_NONE, 0, '0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
